ccsds123_stream_ctrl: RTL and testbench
=======================================

CCSDS123_STREAM_CTRL -- requirements
Module: ccsds123_stream_ctrl

Interface
REQ-001 Parameter: D, 16, sample width in bits.
REQ-002 Parameter: NX, 4, image columns.
REQ-003 Parameter: NY, 2, image rows.
REQ-004 Parameter: NZ, 2, image bands.
REQ-005 Parameter: CNT_W, 16, width of the image count and images-done counters.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port: clk, in, 1, rising-edge clock.
REQ-008 Port: rst, in, 1, synchronous active-high reset.
REQ-009 Port: cfg_start, in, 1, single-cycle start request.
REQ-010 Port: cfg_num_images, in, CNT_W, number of images to sequence; sampled on an accepted start.
REQ-011 Port: s_tdata, in, D, upstream sample.
REQ-012 Port: s_tvalid, in, 1, upstream sample valid.
REQ-013 Port: s_tready, out, 1, upstream ready.
REQ-014 Port: core_tdata, out, D, sample to the compressor input.
REQ-015 Port: core_tvalid, out, 1, compressor input valid.
REQ-016 Port: core_tready, in, 1, compressor input ready.
REQ-017 Port: core_out_tvalid, in, 1, compressor output valid (monitored only).
REQ-018 Port: core_out_tlast, in, 1, compressor output last word of image (monitored only).
REQ-019 Port: busy, out, 1, high in any state other than IDLE.
REQ-020 Port: done, out, 1, one-cycle pulse when the batch completes.
REQ-021 Port: images_done, out, CNT_W, images fully emitted in the current batch.
REQ-022 Port: err_early_last, out, 1, sticky flag for an output tlast seen while feeding.

Function
REQ-023 The block SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-024 The passthrough SHALL be combinational: core_tdata=s_tdata, core_tvalid=s_tvalid&&FEED, s_tready=core_tready&&FEED.
REQ-025 An input transfer SHALL be a cycle with s_tvalid&&s_tready, and the sample counter SHALL increment by 1 per transfer.
REQ-026 IDLE SHALL move to FEED on cfg_start when cfg_num_images!=0: latch the count, clear the sample counter, images_done and err_early_last.
REQ-027 IDLE SHALL move to DONE on cfg_start when cfg_num_images==0.
REQ-028 FEED SHALL move to DRAIN on the transfer of sample number NX*NY*NZ-1, and the sample counter SHALL wrap to 0 on that transfer.
REQ-029 In DRAIN, no input SHALL be accepted (s_tready=0, core_tvalid=0).
REQ-030 DRAIN SHALL leave on a cycle with core_out_tvalid&&core_out_tlast: images_done increments, then the state moves to DONE if the new value equals the latched count, otherwise to FEED.
REQ-031 core_out_tvalid&&core_out_tlast in FEED or IDLE SHALL set err_early_last, be ignored for counting, and not change state.
REQ-032 DONE SHALL assert done for exactly one cycle, then return to IDLE; images_done SHALL hold its value until the next accepted start.
REQ-033 cfg_start SHALL be ignored in FEED, DRAIN and DONE.
REQ-034 The sample counter SHALL be wide enough for NX*NY*NZ-1 (clog2).
REQ-035 images_done SHALL never wrap, because the batch ends at the latched count.

Reset
REQ-036 While rst is high at a rising edge, the next state SHALL be IDLE with sample counter=0, images_done=0, err_early_last=0, done=0 and busy=0.
REQ-037 Resetting mid-FEED or mid-DRAIN SHALL abort the batch; s_tready and core_tvalid SHALL be 0 from the cycle after the reset edge.
REQ-038 Reset SHALL take priority over cfg_start in the same cycle.

Verification
REQ-039 Start with num=1, 16 samples, core_tready=1, then tlast 5 cycles later: 16 transfers, DRAIN with s_tready=0, images_done=1, done high one cycle, busy low after.
REQ-040 Start with num=2, random core_tready, 40 offered samples: exactly 16 samples pass per image, the 17th is held until the first tlast, done comes after the second tlast, images_done=2.
REQ-041 Start with num=0: done pulses one cycle later, no input transfer occurs, images_done=0.
REQ-042 tlast pulsed during FEED at sample 7: err_early_last=1 and stays set, state stays FEED, images_done unchanged.
REQ-043 rst asserted at sample 9 of image 1: the next cycle shows IDLE with all outputs at reset values, and a following start with num=1 completes normally.
REQ-044 cfg_start pulsed during DRAIN with num=5: it is ignored, the latched count is unchanged, and the batch ends at the original count.

Source files
------------

// File: rtl/ccsds123_stream_ctrl.sv
// ccsds123_stream_ctrl: batch sequencer in front of a CCSDS-123 compressor.
// Ports:
//    clk, rst                        clock, synchronous active-high reset
//    cfg_start, cfg_num_images       batch start request and image count
//    s_tdata/s_tvalid/s_tready       upstream sample stream
//    core_tdata/core_tvalid/core_tready  compressor input stream
//    core_out_tvalid/core_out_tlast  compressor output, monitored only
//    busy, done, images_done         batch status
//    err_early_last                  sticky output-tlast-while-feeding flag
module ccsds123_stream_ctrl #(
   parameter int D     = 16,
   parameter int NX    = 4,
   parameter int NY    = 2,
   parameter int NZ    = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_num_images,
   input  logic [D-1:0]     s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic [D-1:0]     core_tdata,
   output logic             core_tvalid,
   input  logic             core_tready,
   input  logic             core_out_tvalid,
   input  logic             core_out_tlast,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] images_done,
   output logic             err_early_last
);

   localparam int NS = NX * NY * NZ;
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [SW-1:0]    LAST = SW'(NS - 1);
   localparam logic [SW-1:0]    SONE = SW'(1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [SW-1:0]    cnt_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] img_q;
   logic             err_q;
   logic             busy_q;
   logic             done_q;

   logic             feed;
   logic             xfer;
   logic             out_last;
   logic [CNT_W-1:0] img_inc;

   assign feed        = (state_q == S_FEED);
   assign core_tdata  = s_tdata;
   assign core_tvalid = s_tvalid & feed;
   assign s_tready    = core_tready & feed;
   assign xfer        = s_tvalid & s_tready;
   assign out_last    = core_out_tvalid & core_out_tlast;
   assign img_inc     = img_q + ONE;

   assign busy           = busy_q;
   assign done           = done_q;
   assign images_done    = img_q;
   assign err_early_last = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         img_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (cfg_start) begin
                  // Any start opens a new batch, so the
                  // previous batch's status is cleared.
                  cnt_q  <= '0;
                  img_q  <= '0;
                  err_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (cfg_num_images != '0) begin
                     num_q   <= cfg_num_images;
                     state_q <= S_FEED;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end else if (out_last) begin
                  err_q <= 1'b1;
               end
            end
            S_FEED: begin
               if (xfer) begin
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_DRAIN;
                  end else begin
                     cnt_q <= cnt_q + SONE;
                  end
               end
               if (out_last) begin
                  err_q <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_last) begin
                  img_q <= img_inc;
                  if (img_inc == num_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_FEED;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccsds123_stream_ctrl.sv
// tb_ccsds123_stream_ctrl: vector table, directed batch sequences and
// random traffic checked against a transaction-count reference model.
module tb_ccsds123_stream_ctrl;

   localparam int D     = 16;
   localparam int NX    = 4;
   localparam int NY    = 2;
   localparam int NZ    = 2;
   localparam int CNT_W = 16;
   localparam int NS    = NX * NY * NZ;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start;
   logic [CNT_W-1:0] cfg_num_images;
   logic [D-1:0]     s_tdata;
   logic             s_tvalid;
   logic             s_tready;
   logic [D-1:0]     core_tdata;
   logic             core_tvalid;
   logic             core_tready;
   logic             core_out_tvalid;
   logic             core_out_tlast;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] images_done;
   logic             err_early_last;

   int checks   = 0;
   int failures = 0;
   int xfers    = 0;

   ccsds123_stream_ctrl #(
      .D(D), .NX(NX), .NY(NY), .NZ(NZ), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cfg_start(cfg_start),
      .cfg_num_images(cfg_num_images),
      .s_tdata(s_tdata),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .core_tdata(core_tdata),
      .core_tvalid(core_tvalid),
      .core_tready(core_tready),
      .core_out_tvalid(core_out_tvalid),
      .core_out_tlast(core_out_tlast),
      .busy(busy),
      .done(done),
      .images_done(images_done),
      .err_early_last(err_early_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic             start;
      logic [CNT_W-1:0] num;
      logic             tv;
      logic             tr;
      logic             tl;
      logic             busy;
      logic             done;
      logic             srdy;
      logic             cval;
      logic [CNT_W-1:0] img;
      logic             err;
   } vec_t;

   vec_t tbl[10];
   vec_t none;

   // Reference model: a batch is a run of num images of NS samples.
   // Input is open while fewer than NS*(imgs+1) samples have been taken.
   bit m_active;
   bit m_done_cyc;
   bit m_err;
   int m_num;
   int m_taken;
   int m_imgs;

   function automatic bit m_feeding();
      return m_active && (m_taken < NS * (m_imgs + 1));
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic model_update();
      bit feeding;
      bit tl;
      feeding = m_feeding();
      tl = core_out_tvalid && core_out_tlast;
      if (rst) begin
         m_active = 0; m_done_cyc = 0; m_err = 0;
         m_num = 0; m_taken = 0; m_imgs = 0;
      end else if (m_done_cyc) begin
         m_done_cyc = 0;
      end else if (!m_active) begin
         if (cfg_start) begin
            m_imgs = 0; m_err = 0; m_taken = 0;
            if (cfg_num_images == 0) m_done_cyc = 1;
            else begin
               m_active = 1;
               m_num = int'(cfg_num_images);
            end
         end else if (tl) begin
            m_err = 1;
         end
      end else if (feeding) begin
         if (s_tvalid && core_tready) m_taken++;
         if (tl) m_err = 1;
      end else if (tl) begin
         m_imgs++;
         if (m_imgs == m_num) begin
            m_active = 0;
            m_done_cyc = 1;
         end
      end
   endtask

   // One clock: compare at negedge, advance model at posedge.
   task automatic cycle(input bit use_row, input vec_t row);
      bit feeding;
      logic [D+CNT_W+5:0] got, exp;
      @(negedge clk);
      feeding = m_feeding();
      got = {busy, done, s_tready, core_tvalid,
             images_done, err_early_last, core_tdata};
      exp = {m_active || m_done_cyc, m_done_cyc,
             core_tready && feeding, s_tvalid && feeding,
             CNT_W'(m_imgs), m_err, s_tdata};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL model t=%0t got=%0h exp=%0h", $time, got, exp);
      end
      if (s_tvalid === 1'b1 && s_tready === 1'b1) xfers++;
      if (use_row)
         chk("vec", {busy, done, s_tready, core_tvalid,
                     images_done, err_early_last},
             {row.busy, row.done, row.srdy, row.cval,
              row.img, row.err});
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(0, none);
      cycle(0, none);
      rst = 1'b0;
   endtask

   task automatic start_batch(input int n);
      cfg_start = 1'b1;
      cfg_num_images = CNT_W'(n);
      cycle(0, none);
      cfg_start = 1'b0;
   endtask

   task automatic feed(input int n);
      s_tvalid = 1'b1;
      core_tready = 1'b1;
      repeat (n) begin
         s_tdata = D'($urandom);
         cycle(0, none);
      end
      s_tvalid = 1'b0;
   endtask

   task automatic pulse_tlast();
      core_out_tvalid = 1'b1;
      core_out_tlast = 1'b1;
      cycle(0, none);
      core_out_tvalid = 1'b0;
      core_out_tlast = 1'b0;
   endtask

   initial begin
      tbl[0] = '{0,1,0,1,1,0, 0,0,0,0,0,0};
      tbl[1] = '{0,0,0,1,1,0, 1,1,0,0,0,0};
      tbl[2] = '{0,0,0,0,1,1, 0,0,0,0,0,0};
      tbl[3] = '{0,0,0,0,1,0, 0,0,0,0,0,1};
      tbl[4] = '{0,1,1,0,1,0, 0,0,0,0,0,1};
      tbl[5] = '{0,0,0,1,0,0, 1,0,0,1,0,0};
      tbl[6] = '{0,0,0,0,1,0, 1,0,1,0,0,0};
      tbl[7] = '{1,1,1,1,1,0, 1,0,1,1,0,0};
      tbl[8] = '{0,0,0,1,1,0, 0,0,0,0,0,0};
      tbl[9] = '{0,0,0,0,1,0, 0,0,0,0,0,0};
      none   = '{0,0,0,0,0,0, 0,0,0,0,0,0};

      rst = 1'b1; cfg_start = 1'b0; cfg_num_images = '0;
      s_tdata = '0; s_tvalid = 1'b0; core_tready = 1'b1;
      core_out_tvalid = 1'b0; core_out_tlast = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_img", images_done, 0);
      chk("rst_err", err_early_last, 0);
      chk("rst_rdy", s_tready, 0);

      // Vector table: num=0, idle tlast, start clears, reset priority
      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         cfg_start = tbl[i].start;
         cfg_num_images = tbl[i].num;
         s_tvalid = tbl[i].tv;
         core_tready = tbl[i].tr;
         core_out_tvalid = tbl[i].tl;
         core_out_tlast = tbl[i].tl;
         s_tdata = D'($urandom);
         cycle(1, tbl[i]);
      end
      rst = 1'b0; cfg_start = 1'b0; s_tvalid = 1'b0;
      core_out_tvalid = 1'b0; core_out_tlast = 1'b0;

      // Single image, tlast five cycles into drain
      do_reset();
      xfers = 0;
      start_batch(1);
      feed(NS);
      chk("one_xfers", xfers, NS);
      chk("one_drain_rdy", s_tready, 0);
      s_tvalid = 1'b1;
      repeat (5) cycle(0, none);
      s_tvalid = 1'b0;
      chk("one_hold", xfers, NS);
      pulse_tlast();
      chk("one_done", done, 1);
      chk("one_img", images_done, 1);
      cycle(0, none);
      chk("one_done_off", done, 0);
      chk("one_busy_off", busy, 0);
      chk("one_img_hold", images_done, 1);

      // Two images, random core_tready, 40 offered samples
      begin
         int dl = 0;
         int tln = 0;
         bit got = 0;
         do_reset();
         xfers = 0;
         start_batch(2);
         for (int t = 0; t < 600 && !got; t++) begin
            s_tvalid = (xfers < 40);
            s_tdata = D'(xfers + 16'h1000);
            core_tready = 1'($urandom % 2);
            core_out_tvalid = 1'b0;
            core_out_tlast = 1'b0;
            if (m_active && !m_feeding()) begin
               dl++;
               if (dl >= 3) begin
                  dl = 0;
                  tln++;
                  core_out_tvalid = 1'b1;
                  core_out_tlast = 1'b1;
                  chk($sformatf("two_img%0d_xfers", tln), xfers, NS * tln);
               end
            end
            cycle(0, none);
            if (done === 1'b1) got = 1;
         end
         s_tvalid = 1'b0; core_out_tvalid = 1'b0; core_out_tlast = 1'b0;
         core_tready = 1'b1;
         chk("two_done", got, 1);
         chk("two_img", images_done, 2);
         chk("two_total", xfers, 2 * NS);
         cycle(0, none);
      end

      // Early tlast while feeding
      do_reset();
      start_batch(1);
      feed(7);
      pulse_tlast();
      chk("early_err", err_early_last, 1);
      chk("early_feed", s_tready, 1);
      chk("early_img", images_done, 0);
      feed(NS - 7);
      chk("early_sticky", err_early_last, 1);
      pulse_tlast();
      chk("early_done", done, 1);
      cycle(0, none);
      chk("early_after", err_early_last, 1);

      // Reset in the middle of image 1, then a clean batch
      do_reset();
      start_batch(2);
      feed(NS);
      pulse_tlast();
      chk("mid_img1", images_done, 1);
      feed(9);
      rst = 1'b1; s_tvalid = 1'b1; core_tready = 1'b1;
      cycle(0, none);
      rst = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_rdy", s_tready, 0);
      chk("mid_val", core_tvalid, 0);
      chk("mid_img", images_done, 0);
      chk("mid_done", done, 0);
      s_tvalid = 1'b0;
      start_batch(1);
      feed(NS);
      pulse_tlast();
      chk("mid_re_done", done, 1);
      chk("mid_re_img", images_done, 1);
      cycle(0, none);

      // Start during drain is ignored
      do_reset();
      start_batch(2);
      feed(NS);
      cfg_start = 1'b1;
      cfg_num_images = CNT_W'(5);
      cycle(0, none);
      cfg_start = 1'b0;
      chk("ign_busy", busy, 1);
      chk("ign_rdy", s_tready, 0);
      pulse_tlast();
      chk("ign_img1", images_done, 1);
      chk("ign_nodone", done, 0);
      feed(NS);
      pulse_tlast();
      chk("ign_done", done, 1);
      chk("ign_img2", images_done, 2);
      cycle(0, none);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom % 200 == 0);
         core_out_tvalid = 1'($urandom % 2);
         core_out_tlast = ($urandom % 10 == 0);
         cfg_start = ($urandom % 20 == 0) && !core_out_tlast;
         cfg_num_images = CNT_W'($urandom % 4);
         s_tvalid = ($urandom % 4 != 0);
         core_tready = ($urandom % 3 != 0);
         s_tdata = D'($urandom);
         cycle(0, none);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
